multicycle_controller: RTL and testbench



---
 rtl/multicycle_controller.sv | 233 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core. It sequences one instruction at a time over the
// shared memory port and the single ALU, and waits on mem_ready when MEM_WAIT_EN is set.
module multicycle_controller #(
    parameter int unsigned CNT_W       = 32,
    parameter bit          MEM_WAIT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             Zero,
    input  logic             lt,
    input  logic             ltu,
    input  logic             mem_ready,
    output logic             AdrSrc,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             done,
    output logic             trap,
    output logic [CNT_W-1:0] instret,
    output logic [4:0]       state
);

    typedef enum logic [4:0] {
        StFetch   = 5'd0,  StDecode  = 5'd1,  StMemAdr  = 5'd2,  StMemRd = 5'd3,
        StMemWb   = 5'd4,  StMemWr   = 5'd5,  StExecR   = 5'd6,  StExecI = 5'd7,
        StAluWb   = 5'd8,  StBranch  = 5'd9,  StJalAdr  = 5'd10, StJalrAdr = 5'd11,
        StLink    = 5'd12, StJump    = 5'd13, StLui     = 5'd14, StAuipc = 5'd15,
        StHalt    = 5'd16, StTrap    = 5'd17
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam logic [2:0] AluAdd  = 3'b000;
    localparam logic [2:0] AluSub  = 3'b001;
    localparam logic [2:0] AluAnd  = 3'b010;
    localparam logic [2:0] AluOr   = 3'b011;
    localparam logic [2:0] AluPass = 3'b100;
    localparam logic [2:0] AluSlt  = 3'b101;
    localparam logic [2:0] AluSltu = 3'b110;
    localparam logic [2:0] AluXor  = 3'b111;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q;
    logic             ready, taken, shift, r_bad;
    logic [2:0]       alu_funct;

    assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign shift = (func3 == 3'b001) || (func3 == 3'b101);
    // Shift encodings and unknown funct7 values decode as illegal.
    assign r_bad = shift || ((func7 != 7'b0000000) && (func7 != 7'b0100000)) ||
                   ((func7 == 7'b0100000) && (func3 != 3'b000));

    always_comb begin
        case (func3)
            3'b000:  taken = Zero;
            3'b001:  taken = ~Zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        case (func3)
            3'b000:  alu_funct = (op == OpR && func7 == 7'b0100000) ? AluSub : AluAdd;
            3'b111:  alu_funct = AluAnd;
            3'b110:  alu_funct = AluOr;
            3'b100:  alu_funct = AluXor;
            3'b010:  alu_funct = AluSlt;
            3'b011:  alu_funct = AluSltu;
            default: alu_funct = AluAdd;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:   if (ready) state_d = StDecode;
            StDecode: begin
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpR:      state_d = r_bad ? StTrap : StExecR;
                    OpI:      state_d = shift ? StTrap : StExecI;
                    OpBranch: state_d = (func3[2:1] == 2'b01) ? StTrap : StBranch;
                    OpJal:    state_d = StJalAdr;
                    OpJalr:   state_d = StJalrAdr;
                    OpLui:    state_d = StLui;
                    OpAuipc:  state_d = StAuipc;
                    OpSystem: state_d = StHalt;
                    default:  state_d = StTrap;
                endcase
            end
            StMemAdr:  state_d = (op == OpStore) ? StMemWr : StMemRd;
            StMemRd:   if (ready) state_d = StMemWb;
            StMemWr:   if (ready) state_d = StFetch;
            StMemWb, StAluWb, StBranch, StJump: state_d = StFetch;
            StExecR, StExecI, StLui, StAuipc:   state_d = StAluWb;
            StJalAdr, StJalrAdr:                state_d = StLink;
            StLink:    state_d = StJump;
            StHalt:    state_d = StHalt;
            StTrap:    state_d = StTrap;
            default:   state_d = StTrap;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == StFetch && state_q != StFetch) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign instret = instret_q;
    assign state   = state_q;

    always_comb begin
        AdrSrc     = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 3'b000;
        ALUControl = AluAdd;
        done       = 1'b0;
        trap       = 1'b0;
        unique case (state_q)
            StFetch: begin
                MemRead   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = ready;
                PCWrite   = ready;
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b010;
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OpStore) ? 3'b001 : 3'b000;
            end
            StMemRd: begin
                MemRead = 1'b1;
                AdrSrc  = 1'b1;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            StMemWr: begin
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
            end
            StExecR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_funct;
            end
            StExecI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_funct;
            end
            StAluWb:  RegWrite = 1'b1;
            StBranch: begin
                ALUSrcA    = 2'b10;
                ALUControl = AluSub;
                PCWrite    = taken;
            end
            StJalAdr: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b011;
            end
            StJalrAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            StLink: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegWrite  = 1'b1;
            end
            StJump:  PCWrite = 1'b1;
            StLui: begin
                ALUSrcB    = 2'b01;
                ImmSrc     = 3'b100;
                ALUControl = AluPass;
            end
            StAuipc: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b100;
            end
            StHalt:  done = 1'b1;
            StTrap:  trap = 1'b1;
            default: trap = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks instruction classes through the FSM and
// compares cycle counts, strobes and counters against hand-computed values.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  op = 7'b0;
    logic [2:0]  func3 = 3'b0;
    logic [6:0]  func7 = 7'b0;
    logic        Zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b1;
    logic        AdrSrc, MemRead, MemWrite, IRWrite, PCWrite, RegWrite, done, trap;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0]  ImmSrc, ALUControl;
    logic [31:0] instret;
    logic [4:0]  state;

    int n_cmp = 0;
    int n_err = 0;
    int exp_ret = 0;

    // Per-instruction observations gathered by run_instr.
    int trace [0:47];
    int n_rw, n_pc, n_mem, rw_state, pc_state, rs_rw, alu_exec;

    multicycle_controller #(.CNT_W(32), .MEM_WAIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
        .Zero(Zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .AdrSrc(AdrSrc), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .done(done),
        .trap(trap), .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("reset_state", 32'(state), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_ret = 0;
    endtask

    // Runs one instruction from FETCH back to FETCH; memory waits are applied in MEMRD/MEMWR.
    task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic [6:0] f7, input int waits, input int exp_cyc);
        int n = 0;
        int w = waits;
        op = o; func3 = f3; func7 = f7;
        n_rw = 0; n_pc = 0; n_mem = 0; rw_state = -1; pc_state = -1; rs_rw = -1; alu_exec = -1;
        do begin
            if ((state == 5'd3 || state == 5'd5) && w > 0) begin
                mem_ready = 1'b0;
                w--;
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            trace[n] = int'(state);
            if (state != 5'd0) begin
                if (RegWrite) begin n_rw++; rw_state = int'(state); rs_rw = int'(ResultSrc); end
                if (PCWrite) begin n_pc++; pc_state = int'(state); end
                if ((state == 5'd3 || state == 5'd5) && (MemRead | MemWrite) && AdrSrc) n_mem++;
                if (state == 5'd6) alu_exec = int'(ALUControl);
            end
            step();
            n++;
        end while (state != 5'd0 && n < 40);
        trace[n] = int'(state);
        check({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
        exp_ret++;
        check({tag, "_instret"}, instret, 32'(exp_ret));
    endtask

    logic [6:0] bad_op [0:3];
    logic [2:0] bad_f3 [0:3];
    logic [6:0] bad_f7 [0:3];

    initial begin
        bad_op[0] = 7'b0110011; bad_f3[0] = 3'b000; bad_f7[0] = 7'b0000001;
        bad_op[1] = 7'b0010011; bad_f3[1] = 3'b001; bad_f7[1] = 7'b0000000;
        bad_op[2] = 7'b1100011; bad_f3[2] = 3'b011; bad_f7[2] = 7'b0000000;
        bad_op[3] = 7'b0110011; bad_f3[3] = 3'b111; bad_f7[3] = 7'b0100000;

        // Reset values with mem_ready high and then low.
        #3;
        check("rst_state", 32'(state), 32'd0);
        check("rst_memread", 32'(MemRead), 32'd1);
        check("rst_alusrcb", 32'(ALUSrcB), 32'd2);
        check("rst_resultsrc", 32'(ResultSrc), 32'd2);
        check("rst_irwrite_rdy", 32'(IRWrite), 32'd1);
        check("rst_instret", instret, 32'd0);
        check("rst_regwrite", 32'(RegWrite), 32'd0);
        mem_ready = 1'b0;
        #1;
        check("rst_irwrite_nrdy", 32'(IRWrite), 32'd0);
        check("rst_pcwrite_nrdy", 32'(PCWrite), 32'd0);
        mem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        run_instr("add", 7'b0110011, 3'b000, 7'b0000000, 0, 4);
        check("add_alu", 32'(alu_exec), 32'd0);
        run_instr("sub", 7'b0110011, 3'b000, 7'b0100000, 0, 4);
        check("sub_alu", 32'(alu_exec), 32'd1);
        run_instr("sltu", 7'b0110011, 3'b011, 7'b0000000, 0, 4);
        check("sltu_alu", 32'(alu_exec), 32'd6);

        ltu = 1'b0;
        run_instr("bgeu_t", 7'b1100011, 3'b111, 7'b0, 0, 3);
        check("bgeu_t_pcwrite", 32'(n_pc), 32'd1);
        ltu = 1'b1;
        run_instr("bgeu_nt", 7'b1100011, 3'b111, 7'b0, 0, 3);
        check("bgeu_nt_pcwrite", 32'(n_pc), 32'd0);
        ltu = 1'b0;

        run_instr("jalr", 7'b1100111, 3'b000, 7'b0, 0, 5);
        check("jalr_s1", 32'(trace[1]), 32'd1);
        check("jalr_s2", 32'(trace[2]), 32'd11);
        check("jalr_s3", 32'(trace[3]), 32'd12);
        check("jalr_s4", 32'(trace[4]), 32'd13);
        check("jalr_s5", 32'(trace[5]), 32'd0);
        check("jalr_rw_cnt", 32'(n_rw), 32'd1);
        check("jalr_rw_state", 32'(rw_state), 32'd12);
        check("jalr_pc_cnt", 32'(n_pc), 32'd1);
        check("jalr_pc_state", 32'(pc_state), 32'd13);

        run_instr("lw", 7'b0000011, 3'b010, 7'b0, 3, 8);
        check("lw_rw_cnt", 32'(n_rw), 32'd1);
        check("lw_resultsrc", 32'(rs_rw), 32'd1);
        check("lw_memrd_cycles", 32'(n_mem), 32'd4);

        // Abort a load while it stalls in MEMRD.
        op = 7'b0000011; func3 = 3'b010; mem_ready = 1'b1;
        step();
        step();
        mem_ready = 1'b0;
        step();
        step();
        check("mid_state", 32'(state), 32'd3);
        check("mid_instret", instret, 32'd7);
        #2 rst = 1'b1;
        #1;
        check("async_state", 32'(state), 32'd0);
        check("async_instret", instret, 32'd0);
        check("async_memread", 32'(MemRead), 32'd1);
        mem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_ret = 0;

        run_instr("lui", 7'b0110111, 3'b000, 7'b0, 0, 4);
        run_instr("auipc", 7'b0010111, 3'b000, 7'b0, 0, 4);
        run_instr("sw", 7'b0100011, 3'b010, 7'b0, 1, 5);
        check("sw_memwr_cycles", 32'(n_mem), 32'd2);
        check("sw_regwrite", 32'(n_rw), 32'd0);

        do_reset();
        op = 7'b0000000; func3 = 3'b000; func7 = 7'b0;
        step();
        step();
        for (int i = 0; i < 20; i++) begin
            check("trap_flag", 32'(trap), 32'd1);
            step();
        end
        check("trap_state", 32'(state), 32'd17);
        check("trap_instret", instret, 32'd0);
        check("trap_done", 32'(done), 32'd0);

        do_reset();
        op = 7'b1110011;
        step();
        step();
        check("halt_done", 32'(done), 32'd1);
        check("halt_trap", 32'(trap), 32'd0);
        for (int i = 0; i < 5; i++) step();
        check("halt_state", 32'(state), 32'd16);
        check("halt_instret", instret, 32'd0);

        for (int k = 0; k < 4; k++) begin
            do_reset();
            op = bad_op[k]; func3 = bad_f3[k]; func7 = bad_f7[k];
            step();
            step();
            check("illegal_trap", 32'(state), 32'd17);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
